// File: rtl/aes_pkg.sv
// Shared AES constants, output-format encoding and the lane interleave mapping.
package aes_pkg;

    localparam int AES_BLOCK_BITS  = 128;
    localparam int AES_BYTE_BITS   = 8;
    localparam int AES_BLOCK_BYTES = AES_BLOCK_BITS / AES_BYTE_BITS;

    typedef enum logic {
        FMT_CONCAT     = 1'b0,
        FMT_INTERLEAVE = 1'b1
    } fmt_e;

    // Byte position of plaintext byte byte_idx of lane `lane` inside an interleaved beat.
    function automatic int interleave_byte_idx(input int lane, input int byte_idx, input int lanes);
        return byte_idx * lanes + lane;
    endfunction

endpackage

// File: rtl/aes_lane_formatter.sv
// Packs LANES plaintext blocks into one beat, byte-interleaved or lane-concatenated.
module aes_lane_formatter
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  fmt_e                            fmt_i,
    input  logic [0:AES_BLOCK_BITS*LANES-1] plain_i,
    output logic [0:AES_BLOCK_BITS*LANES-1] data_o
);

    // Concatenated is the identity; interleaved scatters each lane's bytes LANES apart.
    always_comb begin
        // NOTE: default assignment first so every path drives data_o and no latch is inferred.
        data_o = plain_i;
        if (fmt_i == FMT_INTERLEAVE) begin
            for (int l = 0; l < LANES; l++) begin
                for (int b = 0; b < AES_BLOCK_BYTES; b++) begin
                    data_o[AES_BYTE_BITS*interleave_byte_idx(l, b, LANES) +: AES_BYTE_BITS] =
                        plain_i[AES_BLOCK_BITS*l + AES_BYTE_BITS*b +: AES_BYTE_BITS];
                end
            end
        end
    end

endmodule

// File: rtl/decryption.sv
// Combinational AES-128 inverse cipher: forward key schedule, then ten inverse rounds.
// Bit 0 of every 128-bit bus is the MSB of byte 0 (FIPS-197 byte order).
module decryption (
    input  logic [0:127] enc_data_i,
    input  logic [0:127] key_i,
    output logic [0:127] plain_o
);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sub_byte(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sub_byte(input logic [7:0] s);
        return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
    endfunction

    // State byte n sits at column n/4, row n%4; round-key words are big-endian by row.
    function automatic logic [0:127] inv_cipher(input logic [0:127] ct, input logic [0:127] key);
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   rcon;
        logic [7:0]   s [16];
        logic [7:0]   u [16];
        logic [0:127] res;
        for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
        rcon = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sub_byte(t[23:16]), sub_byte(t[15:8]), sub_byte(t[7:0]), sub_byte(t[31:24])}
                    ^ {rcon, 24'h000000};
                rcon = xtime(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int n = 0; n < 16; n++) s[n] = ct[8*n +: 8] ^ w[40 + n/4][8*(3 - n%4) +: 8];
        for (int rnd = 9; rnd >= 0; rnd--) begin
            // InvShiftRows folded into the InvSubBytes gather, then AddRoundKey.
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    u[4*c + r] = inv_sub_byte(s[4*((c - r + 4) % 4) + r]);
            for (int n = 0; n < 16; n++) u[n] ^= w[4*rnd + n/4][8*(3 - n%4) +: 8];
            if (rnd != 0) begin
                for (int c = 0; c < 4; c++)
                    for (int i = 0; i < 4; i++)
                        s[4*c + i] = gf_mul(u[4*c + i], 8'h0e)
                                   ^ gf_mul(u[4*c + (i+1)%4], 8'h0b)
                                   ^ gf_mul(u[4*c + (i+2)%4], 8'h0d)
                                   ^ gf_mul(u[4*c + (i+3)%4], 8'h09);
            end else begin
                for (int n = 0; n < 16; n++) s[n] = u[n];
            end
        end
        for (int n = 0; n < 16; n++) res[8*n +: 8] = s[n];
        return res;
    endfunction

    // Whole inverse cipher evaluated combinationally from the registered lane inputs.
    always_comb begin
        plain_o = inv_cipher(enc_data_i, key_i);
    end

endmodule

// File: rtl/aes_decryption_lanes.sv
// Streaming LANES x AES-128 decryptor with valid/ready handshake and a
// PIPE_STAGES-deep register pipeline that stalls as a whole on backpressure.
module aes_decryption_lanes
    import aes_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int PIPE_STAGES = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [0:AES_BLOCK_BITS*LANES-1] enc_data,
    input  logic [0:AES_BLOCK_BITS*LANES-1] cipher_key,
    input  logic                            interleave,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [0:AES_BLOCK_BITS*LANES-1] decrypted_data,
    output logic                            out_interleave
);

    localparam int W = AES_BLOCK_BITS * LANES;

    logic                   adv;
    logic [PIPE_STAGES-1:0] valid_q;   // bit s-1 belongs to stage s
    logic [PIPE_STAGES-1:0] valid_d;
    logic [0:W-1]           s1_data_q;
    logic [0:W-1]           s1_key_q;
    fmt_e                   s1_fmt_q;
    logic [0:W-1]           plain_text;
    logic [0:W-1]           fmt_data;
    logic [0:W-1]           data_d [2:PIPE_STAGES];
    fmt_e                   fmt_d  [2:PIPE_STAGES];
    logic [0:W-1]           data_q [2:PIPE_STAGES];
    fmt_e                   fmt_q  [2:PIPE_STAGES];

    assign out_valid      = valid_q[PIPE_STAGES-1];
    assign adv            = !out_valid || out_ready;
    assign in_ready       = adv && !reset;
    assign decrypted_data = data_q[PIPE_STAGES];
    assign out_interleave = fmt_q[PIPE_STAGES];
    assign valid_d        = {valid_q[PIPE_STAGES-2:0], in_valid};

    // Stage valid bits shift as one unit whenever the pipeline advances.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
        if (reset) begin
            valid_q <= '0;
        end else if (adv) begin
            valid_q <= valid_d;
        end
    end

    // Stage 1 captures the accepted beat.
    always_ff @(posedge clk) begin
        // NOTE: datapath registers carry no reset; valid_q alone says whether their contents mean anything.
        if (in_valid && in_ready) begin
            s1_data_q <= enc_data;
            s1_key_q  <= cipher_key;
            s1_fmt_q  <= fmt_e'(interleave);
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        decryption u_core (
            .enc_data_i (s1_data_q[AES_BLOCK_BITS*l +: AES_BLOCK_BITS]),
            .key_i      (s1_key_q[AES_BLOCK_BITS*l +: AES_BLOCK_BITS]),
            .plain_o    (plain_text[AES_BLOCK_BITS*l +: AES_BLOCK_BITS])
        );
    end

    aes_lane_formatter #(
        .LANES (LANES)
    ) u_fmt (
        .fmt_i   (s1_fmt_q),
        .plain_i (plain_text),
        .data_o  (fmt_data)
    );

    // Next value of each stage 2..PIPE_STAGES: formatter output, then the stage before.
    always_comb begin
        data_d[2] = fmt_data;
        fmt_d[2]  = s1_fmt_q;
        for (int s = 3; s <= PIPE_STAGES; s++) begin
            data_d[s] = data_q[s-1];
            fmt_d[s]  = fmt_q[s-1];
        end
    end

    // Inner stages shift on every advance; the output stage only loads real beats so it
    // keeps the last plaintext while the pipeline runs empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q[PIPE_STAGES] <= '0;
            fmt_q[PIPE_STAGES]  <= FMT_CONCAT;
        end else if (adv) begin
            for (int s = 2; s < PIPE_STAGES; s++) begin
                data_q[s] <= data_d[s];
                fmt_q[s]  <= fmt_d[s];
            end
            if (valid_q[PIPE_STAGES-2]) begin
                data_q[PIPE_STAGES] <= data_d[PIPE_STAGES];
                fmt_q[PIPE_STAGES]  <= fmt_d[PIPE_STAGES];
            end
        end
    end

endmodule

// File: tb/tb_aes_decryption_lanes.sv
// Directed bench: known-answer AES vectors through a 4-lane/2-stage instance and a
// 1-lane/4-stage instance, covering latency, streaming, backpressure and reset.
module tb_aes_decryption_lanes;

    typedef struct {
        logic [0:127] key;
        logic [0:127] ct;
        logic [0:127] pt;
    } kat_t;

    typedef struct {
        logic [0:511] ct;
        logic [0:511] key;
        logic         il;
        logic [0:511] exp;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic         a_in_valid, a_in_ready, a_interleave, a_out_valid, a_out_ready, a_out_il;
    logic [0:511] a_enc, a_key, a_dec;
    logic         b_in_valid, b_in_ready, b_interleave, b_out_valid, b_out_ready, b_out_il;
    logic [0:127] b_enc, b_key, b_dec;

    int total = 0;
    int bad   = 0;

    kat_t  kat [9];
    beat_t tbl [4];

    aes_decryption_lanes #(.LANES(4), .PIPE_STAGES(2)) dut4 (
        .clk(clk), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .enc_data(a_enc), .cipher_key(a_key), .interleave(a_interleave),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .decrypted_data(a_dec), .out_interleave(a_out_il)
    );

    aes_decryption_lanes #(.LANES(1), .PIPE_STAGES(4)) dut1 (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .enc_data(b_enc), .cipher_key(b_key), .interleave(b_interleave),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .decrypted_data(b_dec), .out_interleave(b_out_il)
    );

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Four lanes drawn from the KAT list; expected output formatted from the known plaintexts.
    function automatic beat_t make_beat(input int s0, input int s1, input int s2, input int s3,
                                        input logic il);
        beat_t        bt;
        int           sel [4];
        logic [0:511] pt;
        sel = '{s0, s1, s2, s3};
        for (int l = 0; l < 4; l++) begin
            bt.ct[128*l +: 128]  = kat[sel[l]].ct;
            bt.key[128*l +: 128] = kat[sel[l]].key;
            pt[128*l +: 128]     = kat[sel[l]].pt;
        end
        bt.il  = il;
        bt.exp = pt;
        if (il) begin
            for (int l = 0; l < 4; l++)
                for (int b = 0; b < 16; b++)
                    bt.exp[8*(4*b + l) +: 8] = pt[128*l + 8*b +: 8];
        end
        return bt;
    endfunction

    // Beat i: lanes rotate over four key groups so every lane in a beat has its own key.
    function automatic beat_t stream_beat(input int i);
        int sel [4];
        for (int l = 0; l < 4; l++) begin
            case ((l + i) % 4)
                0:       sel[l] = 0;
                1:       sel[l] = 1 + i % 5;
                2:       sel[l] = 6 + i % 2;
                default: sel[l] = 8;
            endcase
        end
        return make_beat(sel[0], sel[1], sel[2], sel[3], (i % 2) == 1);
    endfunction

    task automatic drive_a(input beat_t bt, input logic v);
        a_in_valid   = v;
        a_enc        = bt.ct;
        a_key        = bt.key;
        a_interleave = bt.il;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        beat_t        bt;
        beat_t        q [$];
        logic [0:511] held;
        logic         held_il;
        logic         acc;
        int           n_acc;
        int           n_out;

        kat[0] = '{key: 128'h000102030405060708090a0b0c0d0e0f, ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                   pt: 128'h00112233445566778899aabbccddeeff};
        kat[1] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, ct: 128'h3925841d02dc09fbdc118597196a0b32,
                   pt: 128'h3243f6a8885a308d313198a2e0370734};
        kat[2] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, ct: 128'h3ad77bb40d7a3660a89ecaf32466ef97,
                   pt: 128'h6bc1bee22e409f96e93d7e117393172a};
        kat[3] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, ct: 128'hf5d3d58503b9699de785895a96fdbaaf,
                   pt: 128'hae2d8a571e03ac9c9eb76fac45af8e51};
        kat[4] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, ct: 128'h43b1cd7f598ece23881b00e3ed030688,
                   pt: 128'h30c81c46a35ce411e5fbc1191a0a52ef};
        kat[5] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, ct: 128'h7b0c785e27e8ad3f8223207104725dd4,
                   pt: 128'hf69f2445df4f9b17ad2b417be66c3710};
        kat[6] = '{key: 128'h0, ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, pt: 128'h0};
        kat[7] = '{key: 128'h0, ct: 128'h0336763e966d92595a567cc9ce537f5e,
                   pt: 128'hf34481ec3cc627bacd5dc3fb08f273e6};
        kat[8] = '{key: 128'h80000000000000000000000000000000, ct: 128'h0edd33d3c621e546455bd8ba1418bec8,
                   pt: 128'h0};

        tbl[0]     = make_beat(0, 0, 0, 0, 1'b1);
        tbl[0].exp = 512'h00000000111111112222222233333333444444445555555566666666777777778888888899999999aaaaaaaabbbbbbbbccccccccddddddddeeeeeeeeffffffff;
        tbl[1]     = make_beat(0, 0, 0, 0, 1'b0);
        tbl[1].exp = {4{128'h00112233445566778899aabbccddeeff}};
        tbl[2]     = make_beat(1, 2, 6, 8, 1'b0);
        tbl[3]     = make_beat(7, 3, 4, 5, 1'b1);

        // Reset with a beat offered: it must not be accepted.
        reset = 1'b1;
        drive_a(tbl[0], 1'b1);
        a_out_ready  = 1'b1;
        b_in_valid   = 1'b0;
        b_out_ready  = 1'b1;
        b_enc        = '0;
        b_key        = '0;
        b_interleave = 1'b0;
        tick();
        tick();
        check("reset in_ready", a_in_ready, 1'b0);
        check("reset out_valid", a_out_valid, 1'b0);
        check("reset data", a_dec, '0);
        check("reset out_interleave", a_out_il, 1'b0);
        check("reset lanes1 out_valid", b_out_valid, 1'b0);
        check("reset lanes1 data", b_dec, '0);
        reset      = 1'b0;
        a_in_valid = 1'b0;
        tick();
        tick();
        check("beat offered in reset lost", a_out_valid, 1'b0);

        // Single beats: one-cycle latency, correct format, output held once idle.
        for (int t = 0; t < 4; t++) begin
            drive_a(tbl[t], 1'b1);
            #1;
            check($sformatf("tbl%0d in_ready", t), a_in_ready, 1'b1);
            tick();
            a_in_valid = 1'b0;
            check($sformatf("tbl%0d out_valid early", t), a_out_valid, 1'b0);
            tick();
            check($sformatf("tbl%0d out_valid", t), a_out_valid, 1'b1);
            check($sformatf("tbl%0d data", t), a_dec, tbl[t].exp);
            check($sformatf("tbl%0d out_interleave", t), a_out_il, tbl[t].il);
            tick();
            check($sformatf("tbl%0d idle out_valid", t), a_out_valid, 1'b0);
            check($sformatf("tbl%0d idle data held", t), a_dec, tbl[t].exp);
        end

        // Streaming: 20 back-to-back beats, in_ready never drops, outputs in order.
        for (int i = 0; i <= 20; i++) begin
            if (i < 20) begin
                drive_a(stream_beat(i), 1'b1);
                #1;
                check($sformatf("stream%0d in_ready", i), a_in_ready, 1'b1);
            end else begin
                a_in_valid = 1'b0;
                #1;
            end
            tick();
            if (i >= 1) begin
                bt = stream_beat(i - 1);
                check($sformatf("stream%0d out_valid", i - 1), a_out_valid, 1'b1);
                check($sformatf("stream%0d data", i - 1), a_dec, bt.exp);
                check($sformatf("stream%0d out_interleave", i - 1), a_out_il, bt.il);
            end
        end
        tick();
        check("stream drained", a_out_valid, 1'b0);

        // Backpressure: out_ready low for 5 cycles while the source keeps offering.
        n_acc = 0;
        n_out = 0;
        for (int c = 0; c < 40; c++) begin
            if (n_acc < 12) drive_a(stream_beat(n_acc), 1'b1);
            else            a_in_valid = 1'b0;
            a_out_ready = !(c >= 3 && c < 8);
            #1;
            if (c >= 3 && c < 8) begin
                check($sformatf("bp c%0d out_valid", c), a_out_valid, 1'b1);
                check($sformatf("bp c%0d in_ready", c), a_in_ready, 1'b0);
                if (c == 3) begin
                    held    = a_dec;
                    held_il = a_out_il;
                end else begin
                    check($sformatf("bp c%0d data stable", c), a_dec, held);
                    check($sformatf("bp c%0d fmt stable", c), a_out_il, held_il);
                end
            end
            if (a_out_valid && a_out_ready) begin
                if (q.size() == 0) begin
                    check($sformatf("bp c%0d spurious out_valid", c), a_out_valid, 1'b0);
                end else begin
                    bt = q.pop_front();
                    check($sformatf("bp out%0d data", n_out), a_dec, bt.exp);
                    check($sformatf("bp out%0d out_interleave", n_out), a_out_il, bt.il);
                    n_out++;
                end
            end
            acc = a_in_valid && a_in_ready;
            tick();
            if (acc) begin
                q.push_back(stream_beat(n_acc));
                n_acc++;
            end
        end
        check("bp accepted count", n_acc, 12);
        check("bp delivered count", n_out, 12);
        check("bp scoreboard empty", q.size(), 0);
        check("bp final out_valid", a_out_valid, 1'b0);

        // Reset with two beats in flight: both are discarded.
        a_out_ready = 1'b1;
        drive_a(stream_beat(3), 1'b1);
        tick();
        drive_a(stream_beat(4), 1'b1);
        tick();
        check("rst flight out_valid before", a_out_valid, 1'b1);
        a_out_ready = 1'b0;
        reset       = 1'b1;
        drive_a(stream_beat(5), 1'b1);
        #1;
        check("rst flight in_ready", a_in_ready, 1'b0);
        tick();
        reset       = 1'b0;
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        check("rst flight out_valid after", a_out_valid, 1'b0);
        check("rst flight data cleared", a_dec, '0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("rst flight no beat k%0d", k), a_out_valid, 1'b0);
        end

        // LANES=1, PIPE_STAGES=4: both formats give the plaintext after 3 cycles.
        for (int m = 0; m < 2; m++) begin
            b_enc        = kat[0].ct;
            b_key        = kat[0].key;
            b_interleave = (m == 0);
            b_in_valid   = 1'b1;
            #1;
            check($sformatf("lanes1 m%0d in_ready", m), b_in_ready, 1'b1);
            tick();
            b_in_valid = 1'b0;
            for (int d = 0; d < 3; d++) begin
                check($sformatf("lanes1 m%0d out_valid early d%0d", m, d), b_out_valid, 1'b0);
                tick();
            end
            check($sformatf("lanes1 m%0d out_valid", m), b_out_valid, 1'b1);
            check($sformatf("lanes1 m%0d data", m), b_dec, 128'h00112233445566778899aabbccddeeff);
            check($sformatf("lanes1 m%0d out_interleave", m), b_out_il, (m == 0));
            tick();
            check($sformatf("lanes1 m%0d single beat", m), b_out_valid, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_decryption_lanes.md
# aes_decryption_lanes

Parametrised, streaming successor to the fixed four-lane 512-bit decryptor. It decrypts `LANES` independent AES-128 blocks per beat, using one `decryption` core per lane. The output can be byte-interleaved across lanes or lane-concatenated, chosen per beat. It adds a valid/ready handshake, a configurable register pipeline with full backpressure, and a synchronous reset. It sits between the cipher-text stream source and the plaintext consumer in the decryption datapath.

## Interface
- `LANES`, default 4: number of 128-bit blocks per beat; range 1..16.
- `PIPE_STAGES`, default 2: register stages from input capture to output register, inclusive; minimum 2.
- `clk`  in  1  rising-edge clock; the block's only clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  block can accept a beat this cycle.
- `enc_data`  in  [0:128*LANES-1]  cipher text; lane l is bits [128*l +: 128], with bit 0 as MSB.
- `cipher_key`  in  [0:128*LANES-1]  per-lane AES-128 key, same lane layout as `enc_data`.
- `interleave`  in  1  format select, captured with the beat: 1 = byte-interleaved, 0 = concatenated.
- `out_valid`  out  1  output beat present.
- `out_ready`  in  1  consumer accepts the output beat.
- `decrypted_data`  out  [0:128*LANES-1]  formatted plaintext.
- `out_interleave`  out  1  format of the beat currently on `decrypted_data`.

## Operation
- Handshake:
  - A beat transfers on any rising edge where valid && ready, on both the input and output sides.
  - `in_valid` must hold, with data stable, until accepted.
  - `out_valid`, `decrypted_data` and `out_interleave` stay stable while `out_valid && !out_ready`.
- Pipeline: stage 1 registers {`enc_data`, `cipher_key`, `interleave`}. `LANES` combinational `decryption` cores operate on stage-1 contents. The formatter output is registered through stages 2..`PIPE_STAGES`. The last stage drives the outputs.
- Global advance: `adv = !out_valid || out_ready`.
  - Every stage's data and valid bit shift only when `adv` is 1.
  - `in_ready = adv && !reset`.
  - A stage holding no valid beat still shifts, so bubbles collapse only at the output.
- Formatting, with byte = 8 bits, b = 0..15 and l = 0..LANES-1:
  - Interleaved: output byte index b*LANES + l = plaintext byte b of lane l.
  - Concatenated: output bits [128*l +: 128] = lane l plaintext.
  - With `LANES`=1 the two formats are identical.
- Empty pipeline: `out_valid`=0 and `decrypted_data` holds its last value. No output transfer occurs.
- Simultaneous output transfer and input accept in the same cycle is legal and gives full throughput of one beat per cycle.

## Timing
- Reset values, applied on the clock edge with `reset`=1: all stage valid bits 0, `out_valid`=0, `decrypted_data`=0, `out_interleave`=0.
- While `reset`=1, `in_ready`=0. A beat offered during reset is not accepted.
- Reset mid-flight discards every in-flight beat; none appears afterwards.
- Latency:
  - A beat accepted on edge k sets `out_valid`=1 after edge k+PIPE_STAGES-1, assuming `out_ready` stayed 1.
  - With the default of 2, output appears one cycle after capture.
  - Each cycle the output stalls adds one cycle.
- Throughput: one beat per clock when `out_ready`=1 continuously.
- Occupancy: at most `PIPE_STAGES` beats are in flight. No beat is dropped or duplicated under any valid/ready pattern.
- The decryption cores are combinational between stage 1 and stage 2. Meeting timing is achieved by raising `PIPE_STAGES` only where the cores are internally retimed; otherwise the extra stages only add buffering.

## Structure
- Shared package `aes_pkg`:
  - `AES_BLOCK_BITS`=128 and `AES_BYTE_BITS`=8.
  - `FMT_CONCAT`=1'b0 and `FMT_INTERLEAVE`=1'b1.
  - The function mapping (lane, byte) to interleaved byte index.
- The existing `decryption` core is instantiated per lane with a generate loop.
- One new combinational sub-module, `aes_lane_formatter` (parameter `LANES`), performs the interleave/concatenate mux. It is shared with the future encryption counterpart.

## Test plan
- FIPS-197 C.1, all 4 lanes: key 000102030405060708090a0b0c0d0e0f, cipher 69c4e0d86a7b0430d8cdb78070b4c55a, `interleave`=1 -> output bytes 00,00,00,00,11,11,11,11,...,ff,ff,ff,ff, with `out_valid` exactly one cycle after acceptance.
- Same stimulus with `interleave`=0 -> 00112233445566778899aabbccddeeff repeated four times; `out_interleave`=0.
- Streaming: 20 back-to-back beats, each lane with a distinct key and cipher text, `out_ready`=1 -> 20 consecutive output cycles in order, `in_ready` never low.
- Backpressure: `out_ready`=0 for 5 cycles while the source keeps `in_valid`=1 -> `in_ready` drops, output held stable, no loss or duplication after release; checked against a scoreboard.
- Reset asserted for one cycle while 2 beats are in flight -> `out_valid`=0 on the following cycle, neither beat ever emerges, and `in_ready`=0 during the reset cycle.
- `LANES`=1, `PIPE_STAGES`=4, with the C.1 vector in both modes -> identical outputs, with latency of 3 cycles after acceptance.
